// File: rtl/acc_stack_unit.sv
// Accumulator with source mux, DEPTH-entry save/restore stack, zero/carry flags, sticky stack error.
// Latency: every action completes on the next rising clk edge; outputs come straight from registers.
// Backpressure: none; overflow/underflow is not stalled but dropped and reported through stk_err.
module acc_stack_unit #(
    parameter int WIDTH = 8,
    parameter int IMM_W = 4,                  // must be < WIDTH
    parameter int DEPTH = 4,                  // power of two, >= 2
    parameter int SPW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,           // asynchronous, active low
    input  logic             load_acc,
    input  logic [1:0]       sel_acc,
    input  logic [IMM_W-1:0] imm,
    input  logic [WIDTH-1:0] reg_data,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    output logic [WIDTH-1:0] acc_data,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic [SPW-1:0]   sp,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    localparam int PTRW = $clog2(DEPTH);

    localparam logic [1:0] SEL_IMM_ZX = 2'b00;
    localparam logic [1:0] SEL_REG    = 2'b01;
    localparam logic [1:0] SEL_ALU    = 2'b10;
    localparam logic [1:0] SEL_IMM_SX = 2'b11;

    localparam logic [SPW-1:0] SP_ONE = SPW'(1);
    localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

    // Stack storage has no reset: entries above sp are never observed.
    logic [WIDTH-1:0] stack_mem [DEPTH];

    logic [WIDTH-1:0] src_dat;
    logic [WIDTH-1:0] top_dat;
    logic [PTRW-1:0]  top_idx;
    logic [PTRW-1:0]  wr_idx;

    logic xchg_req;
    logic pop_req;
    logic push_req;
    logic xchg_ok;
    logic pop_ok;
    logic push_ok;
    logic load_ok;
    logic err_now;

    // Source select; sign extension replicates the immediate's MSB.
    always_comb begin
        src_dat = '0;
        case (sel_acc)
            SEL_IMM_ZX: src_dat = {{(WIDTH-IMM_W){1'b0}}, imm};
            SEL_REG:    src_dat = reg_data;
            SEL_ALU:    src_dat = alu_out;
            SEL_IMM_SX: src_dat = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
            default:    src_dat = '0;
        endcase
    end

    // Status flags derive directly from the registered state.
    assign stk_empty = (sp == '0);
    assign stk_full  = (sp == SP_MAX);
    assign zero_flag = (acc_data == '0);

    // Entry indices: top of stack (sp-1) for pop/exchange, next free slot (sp) for push.
    // When sp is 0 or DEPTH the index aliases a real slot but the *_ok gating suppresses its use.
    assign top_idx = PTRW'(sp - SP_ONE);
    assign wr_idx  = PTRW'(sp);
    assign top_dat = stack_mem[top_idx];

    // Action decode in priority order: exchange, pop, push (optionally with load), load.
    always_comb begin
        xchg_req = push & pop;
        pop_req  = pop & ~push;
        push_req = push & ~pop;

        xchg_ok  = xchg_req & ~stk_empty;
        pop_ok   = pop_req  & ~stk_empty;
        push_ok  = push_req & ~stk_full;

        // Any pop-type request owns acc_data this cycle, even when it fails on an empty stack.
        load_ok  = load_acc & ~pop;

        err_now  = ((xchg_req | pop_req) & stk_empty) | (push_req & stk_full);
    end

    // Stack writes: exchange overwrites the top, push fills the next free slot with the pre-load acc.
    always_ff @(posedge clk) begin
        if (xchg_ok) begin
            stack_mem[top_idx] <= acc_data;
        end else if (push_ok) begin
            stack_mem[wr_idx] <= acc_data;
        end
    end

    // Accumulator: restored from the stack on pop/exchange, otherwise loaded from the mux.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_data <= '0;
        end else if (xchg_ok || pop_ok) begin
            acc_data <= top_dat;
        end else if (load_ok) begin
            acc_data <= src_dat;
        end
    end

    // Carry tracks the ALU only when the ALU result is what got loaded; other loads clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_flag <= 1'b0;
        end else if (load_ok) begin
            carry_flag <= (sel_acc == SEL_ALU) ? alu_carry : 1'b0;
        end
    end

    // Occupancy count; saturates at both ends because failed requests are gated out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
        end else if (pop_ok) begin
            sp <= sp - SP_ONE;
        end else if (push_ok) begin
            sp <= sp + SP_ONE;
        end
    end

    // Sticky error: a fresh error in the same cycle beats a clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_err <= 1'b0;
        end else if (err_now) begin
            stk_err <= 1'b1;
        end else if (clr_err) begin
            stk_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_stack_unit.sv
// Directed bench for acc_stack_unit at default parameters (WIDTH=8, IMM_W=4, DEPTH=4).
// Latency: each vector is applied for one clock and results are checked 1ns after the edge.
// Backpressure: none; overflow/underflow behaviour is exercised explicitly.
module tb_acc_stack_unit;

    logic       clk;
    logic       rst;
    logic       load_acc;
    logic [1:0] sel_acc;
    logic [3:0] imm;
    logic [7:0] reg_data;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [7:0] acc_data;
    logic       zero_flag;
    logic       carry_flag;
    logic [2:0] sp;
    logic       stk_full;
    logic       stk_empty;
    logic       stk_err;

    int n_checks = 0;
    int n_pass   = 0;

    acc_stack_unit #(
        .WIDTH(8),
        .IMM_W(4),
        .DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_acc  (load_acc),
        .sel_acc   (sel_acc),
        .imm       (imm),
        .reg_data  (reg_data),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .acc_data  (acc_data),
        .zero_flag (zero_flag),
        .carry_flag(carry_flag),
        .sp        (sp),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_err   (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one vector for one clock edge, then return all controls to idle at edge+1ns.
    task automatic cyc(input logic ld, input logic [1:0] sel, input logic [3:0] im,
                       input logic [7:0] rd, input logic [7:0] ao, input logic cy,
                       input logic ps, input logic pp, input logic clr);
        load_acc  = ld;
        sel_acc   = sel;
        imm       = im;
        reg_data  = rd;
        alu_out   = ao;
        alu_carry = cy;
        push      = ps;
        pop       = pp;
        clr_err   = clr;
        @(posedge clk);
        #1;
        load_acc  = 1'b0;
        sel_acc   = 2'b00;
        imm       = 4'h0;
        reg_data  = 8'h00;
        alu_out   = 8'h00;
        alu_carry = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        clr_err   = 1'b0;
    endtask

    task automatic ld_reg(input logic [7:0] v);
        cyc(1'b1, 2'b01, 4'h0, v, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_push();
        cyc(1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        cyc(1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    logic [7:0] pop_exp [4];

    initial begin
        rst = 1'b0;
        load_acc = 1'b0; sel_acc = 2'b00; imm = 4'h0; reg_data = 8'h00;
        alu_out = 8'h00; alu_carry = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc",   acc_data,   8'h00);
        check("rst_zero",  zero_flag,  1'b1);
        check("rst_carry", carry_flag, 1'b0);
        check("rst_sp",    sp,         3'd0);
        check("rst_empty", stk_empty,  1'b1);
        check("rst_full",  stk_full,   1'b0);
        check("rst_err",   stk_err,    1'b0);
        rst = 1'b1;

        // Source mux: zero-extended and sign-extended immediates.
        cyc(1'b1, 2'b00, 4'hA, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("imm_zx",      acc_data,   8'h0A);
        check("imm_zx_zero", zero_flag,  1'b0);
        check("imm_zx_cy",   carry_flag, 1'b0);
        cyc(1'b1, 2'b11, 4'hA, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("imm_sx_neg",  acc_data,   8'hFA);
        cyc(1'b1, 2'b11, 4'h5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("imm_sx_pos",  acc_data,   8'h05);

        // Idle cycle holds state.
        cyc(1'b0, 2'b01, 4'h0, 8'hEE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_hold",   acc_data,   8'h05);

        // ALU source with carry, then register source clears carry.
        cyc(1'b1, 2'b10, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("alu_acc",     acc_data,   8'h00);
        check("alu_zero",    zero_flag,  1'b1);
        check("alu_carry",   carry_flag, 1'b1);
        ld_reg(8'h5C);
        check("reg_acc",     acc_data,   8'h5C);
        check("reg_carry",   carry_flag, 1'b0);

        // Fill the stack with 11,22,33,44; first value comes via ALU with carry set.
        cyc(1'b1, 2'b10, 4'h0, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        do_push();
        check("push_keeps_cy", carry_flag, 1'b1);
        check("push1_sp",      sp,         3'd1);
        ld_reg(8'h22); do_push();
        ld_reg(8'h33); do_push();
        ld_reg(8'h44); do_push();
        check("full_sp",     sp,        3'd4);
        check("full_flag",   stk_full,  1'b1);
        check("full_noerr",  stk_err,   1'b0);

        // Overflow push with load: stack untouched, load still lands.
        cyc(1'b1, 2'b01, 4'h0, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovf_sp",      sp,        3'd4);
        check("ovf_err",     stk_err,   1'b1);
        check("ovf_load",    acc_data,  8'h55);

        pop_exp[0] = 8'h44; pop_exp[1] = 8'h33; pop_exp[2] = 8'h22; pop_exp[3] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            do_pop();
            check($sformatf("pop%0d_acc", i), acc_data, pop_exp[i]);
            check($sformatf("pop%0d_sp", i),  sp,       3'(3 - i));
        end
        check("drain_empty", stk_empty, 1'b1);
        check("drain_full",  stk_full,  1'b0);

        // Underflow pop leaves acc alone; clear works; clear loses to a simultaneous error.
        cyc(1'b1, 2'b01, 4'h0, 8'hAB, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("unf_acc",     acc_data,  8'h11);
        check("unf_sp",      sp,        3'd0);
        check("unf_err",     stk_err,   1'b1);
        cyc(1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_err",     stk_err,   1'b0);
        cyc(1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_vs_err",  stk_err,   1'b1);
        cyc(1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Exchange on empty stack: error, no state change.
        cyc(1'b1, 2'b01, 4'h0, 8'hCD, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("xchg_e_acc",  acc_data,  8'h11);
        check("xchg_e_sp",   sp,        3'd0);
        check("xchg_e_err",  stk_err,   1'b1);
        cyc(1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Exchange: acc=11, top=99 -> acc=99, top=11. Load request is ignored.
        ld_reg(8'h99); do_push();
        ld_reg(8'h11);
        cyc(1'b1, 2'b01, 4'h0, 8'hEE, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("xchg_acc",    acc_data,  8'h99);
        check("xchg_sp",     sp,        3'd1);
        check("xchg_err",    stk_err,   1'b0);
        // Save-and-load: pushes 99, acc becomes 77.
        cyc(1'b1, 2'b01, 4'h0, 8'h77, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("svld_acc",    acc_data,  8'h77);
        check("svld_sp",     sp,        3'd2);
        // Pop with load high: pop wins.
        cyc(1'b1, 2'b00, 4'h3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("svld_top",    acc_data,  8'h99);
        do_pop();
        check("xchg_top",    acc_data,  8'h11);
        check("xchg_sp0",    sp,        3'd0);

        // Build sp=3, err=1, carry=1, then assert reset between edges.
        cyc(1'b0, 2'b00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 2'b10, 4'h0, 8'h00, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        do_push(); do_push(); do_push();
        check("pre_rst_sp",  sp,        3'd3);
        check("pre_rst_err", stk_err,   1'b1);
        check("pre_rst_cy",  carry_flag, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_acc",    acc_data,   8'h00);
        check("arst_zero",   zero_flag,  1'b1);
        check("arst_cy",     carry_flag, 1'b0);
        check("arst_sp",     sp,         3'd0);
        check("arst_empty",  stk_empty,  1'b1);
        check("arst_err",    stk_err,    1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_sp", sp,         3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
